// File: rtl/sync_pkg.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module      : sync_pkg
//  Description : Shared constants and helpers for the sync-pulse family.
//                Holds the default and minimum synchronizer depth and a
//                constant function used by the blocks to validate their
//                SYNC_STAGES parameter at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    // Default number of flops in every synchronizer chain.
    localparam int SYNC_STAGES_DEF = 2;

    // Fewer than two flops gives no metastability settling time.
    localparam int SYNC_STAGES_MIN = 2;

    // True when a requested chain depth is legal.
    function automatic bit sync_stages_ok(input int stages);
        return (stages >= SYNC_STAGES_MIN);
    endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_bit_ff.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module      : sync_bit_ff
//  Description : Single-bit N-flop synchronizer. The input is sampled by the
//                first flop of the chain in the destination clock domain and
//                ripples through STAGES flops before being used. All flops
//                clear asynchronously when rst_n is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit_ff
    import sync_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    // Depth guard: a chain shorter than the minimum does not elaborate.
    if (!sync_stages_ok(STAGES)) begin : g_bad_stages
        $error("sync_bit_ff: STAGES=%0d is below the minimum of %0d",
               STAGES, SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain, oldest bit at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_bit_ff
`default_nettype wire

// File: rtl/sync_pulse_slow_to_fast.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module      : sync_pulse_slow_to_fast
//  Description : Carries single-cycle event pulses plus a DATA_W-bit payload
//                from clk_slow into clk_fast with a toggle request / toggle
//                acknowledge handshake. Each accepted event produces exactly
//                one clk_fast pulse on pulse_out with its payload on
//                data_out. Events arriving while a transfer is in flight are
//                dropped.
//                Build option SYNC_S2F_DROP_CNT_EN adds the drop_cnt port, a
//                saturating count of rejected events in the clk_slow domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_pulse_slow_to_fast
    import sync_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef SYNC_S2F_DROP_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic              clk_fast,
    input  logic              rst_n,
    input  logic              clk_slow,
    input  logic              pulse_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              pulse_out,
    output logic [DATA_W-1:0] data_out
`ifdef SYNC_S2F_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    // Depth guard for the two synchronizer chains.
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_pulse_slow_to_fast: SYNC_STAGES=%0d is below the minimum of %0d",
               SYNC_STAGES, SYNC_STAGES_MIN);
    end

    // ------------------------------------------------------------------------
    // clk_slow domain: request toggle, payload hold and returned acknowledge
    // ------------------------------------------------------------------------
    logic              req_tgl_q;
    logic              req_tgl_d;
    logic [DATA_W-1:0] data_hold_q;
    logic [DATA_W-1:0] data_hold_d;
    logic              ack_sync_last;
    logic              accept;

    // clk_fast domain signals, declared here because the ack chain needs one.
    logic              req_sync_last;
    logic              req_d_q;
    logic              req_edge;
    logic              pulse_out_q;
    logic              pulse_out_d;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;

    // A transfer is outstanding until the acknowledge toggle catches up
    // with the request toggle.
    assign busy = req_tgl_q ^ ack_sync_last;

    // Accept only when idle; an accepted event flips the request toggle and
    // captures the payload on the same edge.
    always_comb begin
        accept      = pulse_in & ~busy;
        req_tgl_d   = req_tgl_q;
        data_hold_d = data_hold_q;
        if (accept) begin
            req_tgl_d   = ~req_tgl_q;
            data_hold_d = data_in;
        end
    end

    // Request-side state registers.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_tgl_q   <= 1'b0;
            data_hold_q <= '0;
        end else begin
            req_tgl_q   <= req_tgl_d;
            data_hold_q <= data_hold_d;
        end
    end

    // The acknowledge is the fast side's synchronized copy of the request,
    // returned through its own chain.
    sync_bit_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk_slow),
        .rst_n (rst_n),
        .d_i   (req_sync_last),
        .q_o   (ack_sync_last)
    );

`ifdef SYNC_S2F_DROP_CNT_EN
    // ------------------------------------------------------------------------
    // Optional saturating count of events rejected while busy
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    // Count every slow cycle that presents an event while busy, stopping at
    // the all-ones value rather than wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (pulse_in && busy && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // ------------------------------------------------------------------------
    // clk_fast domain: synchronize the request, detect its edge, deliver
    // ------------------------------------------------------------------------
    sync_bit_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_fast),
        .rst_n (rst_n),
        .d_i   (req_tgl_q),
        .q_o   (req_sync_last)
    );

    // Any change of the synchronized toggle marks one new event.
    assign req_edge = req_sync_last ^ req_d_q;

    // data_hold is only sampled on an edge; by then it has been static since
    // the accept edge and stays so until the acknowledge returns.
    always_comb begin
        pulse_out_d = 1'b0;
        data_out_d  = data_out_q;
        if (req_edge) begin
            pulse_out_d = 1'b1;
            data_out_d  = data_hold_q;
        end
    end

    // Delivery-side registers: edge-detect delay flop, pulse and payload.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q     <= 1'b0;
            pulse_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            req_d_q     <= req_sync_last;
            pulse_out_q <= pulse_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign data_out  = data_out_q;

endmodule : sync_pulse_slow_to_fast
`default_nettype wire

// File: doc/sync_pulse_slow_to_fast.md
# sync_pulse_slow_to_fast

Carries single-cycle event pulses plus a DATA_W-bit payload from the clk_slow domain into the clk_fast domain. A toggle request is sent fast-ward and a toggle acknowledge is returned slow-ward, so each accepted event yields exactly one clk_fast pulse. It sits opposite the fast-to-slow pulse stretcher in the 021 sync-pulse family and serves slow control or status events that fast logic must act on.

## Interface
- DATA_W, 8, payload width (≥1)
- SYNC_STAGES, 2, flops per synchronizer chain (≥2)
- CNT_W, 8, drop counter width (only with SYNC_S2F_DROP_CNT_EN)

- clk_fast  in  1  fast clock; owns pulse_out and data_out
- rst_n  in  1  reset, asynchronous, active-low, shared by both domains
- clk_slow  in  1  slow clock; owns request side
- pulse_in  in  1  event strobe, one clk_slow cycle per event
- data_in  in  DATA_W  payload, valid with pulse_in
- busy  out  1  clk_slow; an event is in flight
- pulse_out  out  1  clk_fast; one-cycle event strobe
- data_out  out  DATA_W  clk_fast; payload of the latest delivered event
- drop_cnt  out  CNT_W  clk_slow; events rejected while busy (macro only)

## Operation
- Slow side holds req_tgl, data_hold[DATA_W], and ack_sync[SYNC_STAGES].
- Accept when pulse_in=1 and busy=0. On accept: req_tgl inverts and data_hold←data_in, same clk_slow edge.
- busy = req_tgl XOR ack_sync[last], combinational from registers.
- pulse_in=1 while busy=1: the event is dropped. req_tgl and data_hold are unchanged.
- Fast side has req_sync[SYNC_STAGES] on req_tgl, then one extra flop req_d.
- Edge detect e = req_sync[last] XOR req_d. On e: pulse_out←1 and data_out←data_hold (already stable and quasi-static). Otherwise pulse_out←0 and data_out holds.
- Acknowledge: ack_sync chain samples req_sync[last] on clk_slow.
- The handshake returns to idle when ack_sync[last] equals req_tgl.
- Pulse held high across N clk_slow cycles counts as N events. Each is accepted or dropped by the busy rule.
- Reset values: busy=0, pulse_out=0, data_out=0, drop_cnt=0, and all toggles and sync flops 0.
- Reset mid-transfer discards the in-flight event. No pulse_out follows reset, because both toggles equal 0.

## Timing
- Forward latency: pulse_out rises SYNC_STAGES+1 or SYNC_STAGES+2 clk_fast edges after the clk_slow edge that toggles req_tgl. The uncertainty is one fast edge from the async phase.
- pulse_out is high exactly one clk_fast cycle per accepted event.
- data_out updates on the same edge that pulse_out rises.
- busy rises on the accept edge and falls SYNC_STAGES to SYNC_STAGES+1 clk_slow edges after req_sync[last] toggles.
- Minimum event spacing without drop ≈ SYNC_STAGES+2 fast cycles plus SYNC_STAGES+1 slow cycles.
- No frequency ratio is required for correctness; fast only needs to be ≥ slow for the intended use.
- Only single-bit toggles cross domains. data_hold is multi-bit, but it is stable from its accept edge until busy falls.

## Configuration
- SYNC_S2F_DROP_CNT_EN defined: drop_cnt is present. It increments on each clk_slow edge with pulse_in=1 and busy=1, and saturates at 2^CNT_W−1.
- SYNC_S2F_DROP_CNT_EN undefined: the drop_cnt port and its logic are absent. Drops are silent.

## Structure
- Shared package sync_pkg holds SYNC_STAGES_DEF=2 and SYNC_STAGES_MIN=2, plus an elaboration check for SYNC_STAGES ≥ SYNC_STAGES_MIN.
- Sub-module sync_bit_ff is a parameterized single-bit N-flop synchronizer with async active-low reset. It is instantiated twice: req into clk_fast and ack into clk_slow.

## Test plan
- Single event: clk_slow 10 ns, clk_fast 3 ns, pulse_in with data_in=0xA5 → one pulse_out within SYNC_STAGES+2 fast cycles, data_out=0xA5 held; busy drops later; no second pulse.
- Back-to-back: pulse_in on two consecutive slow cycles (0x11, 0x22) → only 0x11 delivered. With macro, drop_cnt=1.
- Spaced stream: 20 events 0x00..0x13, each issued once busy=0 → 20 pulses, payloads in order, drop_cnt=0.
- Saturation (macro, CNT_W=2): 6 events rejected while busy → drop_cnt sticks at 3.
- Reset mid-flight: assert rst_n low one slow cycle after accept → pulse_out never asserts, data_out=0, busy=0. A post-reset event 0x3C delivers normally.
- Ratio sweep: fast:slow ratios 1:1, 3:1 and 7:1 with random phase → every accepted event gives exactly one pulse_out with the correct payload.
